mo_tape_recorder: RTL and testbench
===================================

// Module: mo_tape_recorder
// PURPOSE
//  Records the MO5/MO6 cassette output to DDRAM as 8-bit mono PCM and serves it back to the HPS as a WAV file on ioctl upload.
//  It is the save-direction counterpart of the WAV tape loader and sits inside mo_core beside the tape player.
//  DDRAM access uses a dedicated port; arbitration with the player is done upstream.
// PARAMETERS
//  SAMPLE_DIV  907           sysclk cycles per PCM sample (one tick every SAMPLE_DIV cycles)
//  RATE        44100         sample rate written into the WAV header, Hz
//  BASE_ADDR   29'h0080_0000 DDRAM base address, in 64-bit word units
//  MAX_WORDS   2**20         capacity in 64-bit words; byte length saturates at MAX_WORDS*8
// PORTS
//  sysclk           in   1   system clock
//  reset            in   1   synchronous, active-high reset
//  arm              in   1   record enable (OSD); a rising edge starts a new take
//  motor            in   1   cassette motor on; samples are taken only while motor and arm are both high
//  cas_out          in   1   cassette output bit from the PIA
//  recording        out  1   high while samples are being captured
//  overflow         out  1   sticky; set on a dropped sample or a full buffer; cleared by a new take
//  byte_len         out  27  number of PCM bytes stored
//  ddram_busy       in   1   ddram_addr/din/we/rd are held stable while this is high
//  ddram_burstcnt   out  8   always 1
//  ddram_addr       out  29  BASE_ADDR + word index
//  ddram_din        out  64  sample n goes to byte lane n%8
//  ddram_be         out  8   valid-lane mask
//  ddram_we         out  1   write request
//  ddram_rd         out  1   read request, single beat
//  ddram_dout       in   64  read data
//  ddram_dout_ready in   1   read data valid
//  ioctl_upload     in   1   HPS upload in progress
//  ioctl_rd         in   1   one-cycle byte request pulse
//  ioctl_addr       in   25  requested file byte offset
//  ioctl_din        out  8   returned file byte
//  ioctl_wait       out  1   high from the cycle after ioctl_rd until ioctl_din is valid
// BEHAVIOUR
//  Reset values: all outputs 0 except ddram_burstcnt=1. Internal state: REC_IDLE, D_IDLE, word cache invalid.
//  Record FSM has three states:
//   REC_IDLE -> REC_RUN on a rising edge of arm while ioctl_upload=0; this clears byte_len, overflow and the pack register.
//   REC_RUN  -> REC_FLUSH when arm falls or ioctl_upload rises.
//   REC_FLUSH: the partial word is written with be = lanes 0..(byte_len%8)-1; if byte_len%8=0 nothing is written. Then -> REC_IDLE.
//  Sampling and packing:
//   The tick counter runs freely and wraps at SAMPLE_DIV-1.
//   On a tick, with REC_RUN and motor=1, the sample is cas_out ? 8'hC0 : 8'h40, written to lane byte_len[2:0]; byte_len increments.
//   When lane 7 fills, the word moves to a 1-deep holding register.
//   If the holding register is still occupied at that moment: the word is dropped, overflow=1, byte_len is not advanced past the word.
//   When byte_len reaches MAX_WORDS*8: further samples are ignored, overflow=1, the FSM stays in REC_RUN.
//   recording = (REC_RUN & motor).
//  DDRAM port FSM: D_IDLE, D_WR, D_RD, D_RDWAIT.
//   Priority: a pending write (holding register or flush) wins over a read.
//   we/rd stay asserted until the first cycle with ddram_busy=0; that cycle completes the request.
//   D_RDWAIT ends on ddram_dout_ready, which loads the word cache with its word address.
//  Upload:
//   ioctl_rd latches ioctl_addr and raises ioctl_wait.
//   Header (addr<44): the byte comes from the header ROM; ioctl_din is valid with wait low 2 cycles after ioctl_rd.
//   Data (d = addr-44): if d >= byte_len, return 8'h80. On a cache hit for word d>>3, return lane d%8 after 2 cycles.
//    On a miss, issue ddram_rd, then return the byte 1 cycle after dout_ready.
//   A new ioctl_rd while ioctl_wait is high is ignored.
//   The cache is invalidated on any write or a new take.
//  Reset mid-operation: aborts any take or transfer; buffer contents become undefined and byte_len=0.
// CONFIGURATION
//  MO_TAPE_REC_WAVHDR_EN defined: the upload is a 44-byte RIFF/WAVE header followed by the PCM data.
//   Header fields, little-endian: RIFF size = 36+len, fmt chunk 16, PCM=1, channels=1, RATE, byte rate=RATE, block align=1, 8 bits, data size = len.
//  Undefined: raw PCM only; data offset d = ioctl_addr; the header ROM is not built.
// STRUCTURE
//  mo_tape_pkg holds:
//   WAV_HDR_LEN=44, PCM_HI=8'hC0, PCM_LO=8'h40, PCM_PAD=8'h80
//   typedef enum rec_state_t {REC_IDLE, REC_RUN, REC_FLUSH}
//   typedef enum ddr_state_t {D_IDLE, D_WR, D_RD, D_RDWAIT}
//  Sub-module mo_wav_header: combinational index[5:0] + len[26:0] -> byte.
// TESTING
//  1 Arm, motor=1, cas_out alternating every tick for 16 ticks -> two writes at BASE_ADDR and +1, be=8'hFF, din=64'hC040C040C040C040, byte_len=16.
//  2 Arm, 11 samples, drop arm -> flush write at BASE_ADDR+1 with be=8'h07; byte_len=11.
//  3 ddram_busy held high for 2000 cycles during capture -> overflow=1 and exactly one word dropped; we stays stable while busy.
//  4 Upload a 16-byte take with WAVHDR_EN -> bytes 0..3 "RIFF", 4..7 = 52,0,0,0, 40..43 = 16,0,0,0; byte 44 = 8'hC0; byte 60 = 8'h80.
//  5 Sequential upload reads of bytes 44..51 -> exactly one ddram_rd; bytes 45..51 served from the cache with a 2-cycle wait.
//  6 Assert reset mid-REC_RUN with we pending -> next cycle: we=0, recording=0, byte_len=0, overflow=0.

Source files
------------

// File: rtl/mo_tape_pkg.sv
// Shared constants and state types for the MO5/MO6 cassette recorder.
package mo_tape_pkg;

    localparam int unsigned WAV_HDR_LEN = 44;
    localparam logic [7:0]  PCM_HI      = 8'hC0;
    localparam logic [7:0]  PCM_LO      = 8'h40;
    localparam logic [7:0]  PCM_PAD     = 8'h80;

    typedef enum logic [1:0] {REC_IDLE, REC_RUN, REC_FLUSH} rec_state_t;
    typedef enum logic [1:0] {D_IDLE, D_WR, D_RD, D_RDWAIT} ddr_state_t;
    typedef enum logic [1:0] {U_IDLE, U_LOOK, U_MISS} up_state_t;

    // Byte-enable mask covering lanes 0..n-1.
    function automatic logic [7:0] lane_mask(input logic [2:0] n);
        return 8'((9'd1 << n) - 9'd1);
    endfunction

endpackage

// File: rtl/mo_wav_header.sv
// 44-byte RIFF/WAVE header ROM for 8-bit mono PCM; len is the PCM byte count.
module mo_wav_header
    import mo_tape_pkg::*;
#(
    parameter int unsigned RATE = 44100
) (
    input  logic [5:0]  index,
    input  logic [26:0] len,
    output logic [7:0]  data
);

    logic [31:0] word;

    always_comb begin
        word = 32'h0;
        case (index[5:2])
            4'd0:    word = 32'h4646_4952;            // "RIFF"
            4'd1:    word = 32'(len) + 32'd36;
            4'd2:    word = 32'h4556_4157;            // "WAVE"
            4'd3:    word = 32'h2074_6d66;            // "fmt "
            4'd4:    word = 32'd16;
            4'd5:    word = 32'h0001_0001;            // PCM, mono
            4'd6:    word = 32'(RATE);
            4'd7:    word = 32'(RATE);
            4'd8:    word = 32'h0008_0001;            // block align 1, 8 bits
            4'd9:    word = 32'h6174_6164;            // "data"
            4'd10:   word = 32'(len);
            default: word = 32'h0;
        endcase
        data = word[{index[1:0], 3'b000} +: 8];
    end

endmodule

// File: rtl/mo_tape_recorder.sv
// Cassette-output recorder: packs 8-bit PCM into DDRAM and serves it back on ioctl upload.
// Define MO_TAPE_REC_WAVHDR_EN to prefix the upload with a 44-byte WAV header.
module mo_tape_recorder
    import mo_tape_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 907,
    parameter int unsigned RATE       = 44100,
    parameter logic [28:0] BASE_ADDR  = 29'h0080_0000,
    parameter int unsigned MAX_WORDS  = 2**20
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        arm,
    input  logic        motor,
    input  logic        cas_out,
    output logic        recording,
    output logic        overflow,
    output logic [26:0] byte_len,
    input  logic        ddram_busy,
    output logic [7:0]  ddram_burstcnt,
    output logic [28:0] ddram_addr,
    output logic [63:0] ddram_din,
    output logic [7:0]  ddram_be,
    output logic        ddram_we,
    output logic        ddram_rd,
    input  logic [63:0] ddram_dout,
    input  logic        ddram_dout_ready,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait
);

    localparam int unsigned TW        = $clog2(SAMPLE_DIV + 1);
    localparam logic [26:0] MAX_BYTES = 27'(MAX_WORDS * 8);

    rec_state_t  rec_state;
    ddr_state_t  d_state;
    up_state_t   up_state;
    logic [TW-1:0] tick_cnt;
    logic        arm_q, upload_q;
    logic [63:0] pack_q, next_pack;
    logic        hold_valid;
    logic [63:0] hold_data;
    logic [7:0]  hold_be;
    logic [23:0] hold_word;
    logic        cache_valid;
    logic [63:0] cache_data;
    logic [23:0] cache_word;
    logic [24:0] up_addr, data_off;
    logic [23:0] data_word;
    logic        up_hdr;
    logic [7:0]  hdr_byte;
    logic        tick, take_start, wr_done, sample;
    logic [2:0]  lane;

    assign tick       = tick_cnt == TW'(SAMPLE_DIV - 1);
    assign take_start = (rec_state == REC_IDLE) && arm && !arm_q && !ioctl_upload;
    assign wr_done    = (d_state == D_WR) && !ddram_busy;
    assign sample     = tick && (rec_state == REC_RUN) && motor;
    assign lane       = byte_len[2:0];
    assign recording  = (rec_state == REC_RUN) && motor;
    assign ioctl_wait = up_state != U_IDLE;
    assign ddram_burstcnt = 8'd1;
    assign data_word  = {2'b00, data_off[24:3]};

    always_comb begin
        next_pack = pack_q;
        next_pack[{lane, 3'b000} +: 8] = cas_out ? PCM_HI : PCM_LO;
    end

`ifdef MO_TAPE_REC_WAVHDR_EN
    mo_wav_header #(.RATE(RATE)) u_hdr (
        .index (up_addr[5:0]),
        .len   (byte_len),
        .data  (hdr_byte)
    );
    assign up_hdr   = up_addr < 25'(WAV_HDR_LEN);
    assign data_off = up_addr - 25'(WAV_HDR_LEN);
`else
    assign hdr_byte = PCM_PAD;
    assign up_hdr   = 1'b0;
    assign data_off = up_addr;
`endif

    // Record FSM, sample packing and the 1-deep write holding register.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            rec_state  <= REC_IDLE;
            tick_cnt   <= '0;
            arm_q      <= 1'b0;
            upload_q   <= 1'b0;
            byte_len   <= '0;
            overflow   <= 1'b0;
            pack_q     <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_be    <= '0;
            hold_word  <= '0;
        end else begin
            arm_q    <= arm;
            upload_q <= ioctl_upload;
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (wr_done) hold_valid <= 1'b0;
            case (rec_state)
                REC_IDLE: begin
                    if (take_start) begin
                        rec_state <= REC_RUN;
                        byte_len  <= '0;
                        overflow  <= 1'b0;
                        pack_q    <= '0;
                    end
                end
                REC_RUN: begin
                    if (sample) begin
                        if (byte_len >= MAX_BYTES) begin
                            overflow <= 1'b1;
                        end else begin
                            pack_q <= next_pack;
                            if (lane == 3'd7 && hold_valid) begin
                                // Dropped word: rewind so its lanes are refilled.
                                overflow <= 1'b1;
                                byte_len <= {byte_len[26:3], 3'b000};
                            end else begin
                                byte_len <= byte_len + 27'd1;
                                if (lane == 3'd7) begin
                                    hold_valid <= 1'b1;
                                    hold_data  <= next_pack;
                                    hold_be    <= 8'hFF;
                                    hold_word  <= byte_len[26:3];
                                end
                            end
                        end
                    end
                    if (!arm || (ioctl_upload && !upload_q)) rec_state <= REC_FLUSH;
                end
                REC_FLUSH: begin
                    if (lane == 3'd0) begin
                        rec_state <= REC_IDLE;
                    end else if (!hold_valid) begin
                        hold_valid <= 1'b1;
                        hold_data  <= pack_q;
                        hold_be    <= lane_mask(lane);
                        hold_word  <= byte_len[26:3];
                        rec_state  <= REC_IDLE;
                    end
                end
                default: rec_state <= REC_IDLE;
            endcase
        end
    end

    // DDRAM port: writes from the holding register take priority over upload misses.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            d_state     <= D_IDLE;
            ddram_we    <= 1'b0;
            ddram_rd    <= 1'b0;
            ddram_addr  <= '0;
            ddram_din   <= '0;
            ddram_be    <= '0;
            cache_valid <= 1'b0;
            cache_data  <= '0;
            cache_word  <= '0;
        end else begin
            if (take_start) cache_valid <= 1'b0;
            unique case (d_state)
                D_IDLE: begin
                    if (hold_valid) begin
                        ddram_we    <= 1'b1;
                        ddram_addr  <= BASE_ADDR + {5'b0, hold_word};
                        ddram_din   <= hold_data;
                        ddram_be    <= hold_be;
                        cache_valid <= 1'b0;
                        d_state     <= D_WR;
                    end else if (up_state == U_MISS) begin
                        ddram_rd   <= 1'b1;
                        ddram_addr <= BASE_ADDR + {5'b0, data_word};
                        d_state    <= D_RD;
                    end
                end
                D_WR: begin
                    if (!ddram_busy) begin
                        ddram_we <= 1'b0;
                        d_state  <= D_IDLE;
                    end
                end
                D_RD: begin
                    if (!ddram_busy) begin
                        ddram_rd <= 1'b0;
                        d_state  <= D_RDWAIT;
                    end
                end
                D_RDWAIT: begin
                    if (ddram_dout_ready) begin
                        cache_data  <= ddram_dout;
                        cache_word  <= data_word;
                        cache_valid <= !take_start;
                        d_state     <= D_IDLE;
                    end
                end
            endcase
        end
    end

    // Upload byte server.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            up_state  <= U_IDLE;
            up_addr   <= '0;
            ioctl_din <= '0;
        end else begin
            case (up_state)
                U_IDLE: begin
                    if (ioctl_rd) begin
                        up_addr  <= ioctl_addr;
                        up_state <= U_LOOK;
                    end
                end
                U_LOOK: begin
                    up_state <= U_IDLE;
                    if (up_hdr) begin
                        ioctl_din <= hdr_byte;
                    end else if ({2'b00, data_off} >= byte_len) begin
                        ioctl_din <= PCM_PAD;
                    end else if (cache_valid && cache_word == data_word) begin
                        ioctl_din <= cache_data[{data_off[2:0], 3'b000} +: 8];
                    end else begin
                        up_state <= U_MISS;
                    end
                end
                U_MISS: begin
                    if (d_state == D_RDWAIT && ddram_dout_ready) begin
                        ioctl_din <= ddram_dout[{data_off[2:0], 3'b000} +: 8];
                        up_state  <= U_IDLE;
                    end
                end
                default: up_state <= U_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mo_tape_recorder.sv
// Directed bench for mo_tape_recorder with a behavioural DDRAM model.
module tb_mo_tape_recorder;

    localparam int unsigned DIV  = 160;
    localparam logic [28:0] BASE = 29'h0080_0000;

    logic        sysclk, reset, arm, motor, cas_out;
    logic        recording, overflow;
    logic [26:0] byte_len;
    logic        ddram_busy, ddram_we, ddram_rd, ddram_dout_ready;
    logic [7:0]  ddram_burstcnt, ddram_be;
    logic [28:0] ddram_addr;
    logic [63:0] ddram_din, ddram_dout;
    logic        ioctl_upload, ioctl_rd, ioctl_wait;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;

    mo_tape_recorder #(
        .SAMPLE_DIV (DIV),
        .RATE       (44100),
        .BASE_ADDR  (BASE),
        .MAX_WORDS  (2**20)
    ) dut (
        .sysclk           (sysclk),
        .reset            (reset),
        .arm              (arm),
        .motor            (motor),
        .cas_out          (cas_out),
        .recording        (recording),
        .overflow         (overflow),
        .byte_len         (byte_len),
        .ddram_busy       (ddram_busy),
        .ddram_burstcnt   (ddram_burstcnt),
        .ddram_addr       (ddram_addr),
        .ddram_din        (ddram_din),
        .ddram_be         (ddram_be),
        .ddram_we         (ddram_we),
        .ddram_rd         (ddram_rd),
        .ddram_dout       (ddram_dout),
        .ddram_dout_ready (ddram_dout_ready),
        .ioctl_upload     (ioctl_upload),
        .ioctl_rd         (ioctl_rd),
        .ioctl_addr       (ioctl_addr),
        .ioctl_din        (ioctl_din),
        .ioctl_wait       (ioctl_wait)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bench-side sample phase, reset together with the DUT.
    int unsigned phase = 0;
    initial forever begin
        @(posedge sysclk);
        if (reset) phase = 0;
        else phase = (phase == DIV - 1) ? 0 : phase + 1;
    end

    // Write/read monitor and DDRAM contents.
    logic [28:0] wr_addr[$];
    logic [63:0] wr_din[$];
    logic [7:0]  wr_be[$];
    logic [63:0] mem[logic [28:0]];
    int          rd_cnt = 0, stall_cnt = 0, stall_bad = 0;
    logic        prev_stall = 1'b0;
    logic [28:0] prev_addr;
    logic [63:0] prev_din;

    initial forever begin
        @(negedge sysclk);
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!ddram_we || ddram_addr != prev_addr || ddram_din != prev_din))
                stall_bad++;
            prev_stall = ddram_we && ddram_busy;
            if (prev_stall) stall_cnt++;
            prev_addr = ddram_addr;
            prev_din  = ddram_din;
            if (ddram_we && !ddram_busy) begin
                logic [63:0] w;
                w = mem.exists(ddram_addr) ? mem[ddram_addr] : 64'h0;
                for (int b = 0; b < 8; b++)
                    if (ddram_be[b]) w[8*b +: 8] = ddram_din[8*b +: 8];
                mem[ddram_addr] = w;
                wr_addr.push_back(ddram_addr);
                wr_din.push_back(ddram_din);
                wr_be.push_back(ddram_be);
            end
            if (ddram_rd && !ddram_busy) rd_cnt++;
        end
    end

    // Read responder: data arrives a few cycles after the request completes.
    initial begin
        ddram_dout       = 64'h0;
        ddram_dout_ready = 1'b0;
        forever begin
            @(negedge sysclk);
            if (!reset && ddram_rd && !ddram_busy) begin
                logic [28:0] a;
                a = ddram_addr;
                repeat (3) @(posedge sysclk);
                #1;
                ddram_dout       = mem.exists(a) ? mem[a] : 64'h0;
                ddram_dout_ready = 1'b1;
                @(posedge sysclk);
                #1;
                ddram_dout_ready = 1'b0;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; arm = 1'b0; motor = 1'b0; cas_out = 1'b0; ddram_busy = 1'b0;
        ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0;
        cycles(2);
        reset = 1'b0;
        wr_addr.delete(); wr_din.delete(); wr_be.delete(); mem.delete();
        stall_cnt = 0; stall_bad = 0;
    endtask

    task automatic align();
        do cycles(1); while (phase != DIV / 2);
    endtask

    // Arms and holds each cas_out bit across exactly one tick; busy is high for
    // cycles [bstart, bstart+blen) counted from arming.
    task automatic run_take(input int n, input logic [31:0] pat, input int bstart, input int blen);
        int c;
        c = 0;
        arm = 1'b1;
        for (int i = 0; i < n; i++) begin
            cas_out = pat[i % 32];
            for (int k = 0; k < DIV; k++) begin
                cycles(1);
                c++;
                ddram_busy = (c >= bstart) && (c < bstart + blen);
            end
        end
    endtask

    task automatic ioctl_read(input logic [24:0] a, output logic [7:0] d, output int lat);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        lat = 0;
        do begin
            cycles(1);
            ioctl_rd = 1'b0;
            lat++;
        end while (ioctl_wait && lat < 200);
        check("ioctl_wait_timeout", 64'(ioctl_wait), 64'h0);
        d = ioctl_din;
    endtask

`ifdef MO_TAPE_REC_WAVHDR_EN
    localparam int unsigned OFS = 44;
    localparam int NHDR = 15;
    int          hdr_addr[NHDR] = '{0, 1, 2, 3, 4, 5, 6, 7, 24, 25, 40, 41, 42, 43, 60};
    logic [7:0]  hdr_exp[NHDR]  = '{8'h52, 8'h49, 8'h46, 8'h46, 8'd52, 8'h00, 8'h00, 8'h00,
                                    8'h44, 8'hAC, 8'd16, 8'h00, 8'h00, 8'h00, 8'h80};
`else
    localparam int unsigned OFS = 0;
    localparam int NHDR = 4;
    int          hdr_addr[NHDR] = '{0, 15, 16, 100};
    logic [7:0]  hdr_exp[NHDR]  = '{8'hC0, 8'h40, 8'h80, 8'h80};
`endif

    initial begin
        logic [7:0] d;
        int lat, rd0;

        // Reset state
        do_reset();
        check("rst_recording", 64'(recording), 64'h0);
        check("rst_overflow", 64'(overflow), 64'h0);
        check("rst_byte_len", 64'(byte_len), 64'h0);
        check("rst_burstcnt", 64'(ddram_burstcnt), 64'h1);
        check("rst_we_rd", 64'({ddram_we, ddram_rd, ioctl_wait}), 64'h0);
        check("rst_addr_be", 64'({ddram_addr, ddram_be}), 64'h0);

        // 16 alternating samples, first low
        do_reset();
        motor = 1'b1;
        align();
        run_take(16, 32'hAAAA_AAAA, 0, 0);
        check("t1_recording", 64'(recording), 64'h1);
        arm = 1'b0;
        cycles(20);
        check("t1_recording_off", 64'(recording), 64'h0);
        check("t1_writes", 64'(wr_addr.size()), 64'd2);
        check("t1_addr0", 64'(wr_addr[0]), 64'(BASE));
        check("t1_addr1", 64'(wr_addr[1]), 64'(BASE + 29'd1));
        check("t1_be0", 64'(wr_be[0]), 64'hFF);
        check("t1_be1", 64'(wr_be[1]), 64'hFF);
        check("t1_din0", wr_din[0], 64'hC040C040C040C040);
        check("t1_din1", wr_din[1], 64'hC040C040C040C040);
        check("t1_byte_len", 64'(byte_len), 64'd16);
        check("t1_overflow", 64'(overflow), 64'h0);

        // 11 samples, partial flush
        do_reset();
        motor = 1'b1;
        align();
        run_take(11, 32'hFFFF_FFFF, 0, 0);
        arm = 1'b0;
        cycles(20);
        check("t2_writes", 64'(wr_addr.size()), 64'd2);
        check("t2_flush_addr", 64'(wr_addr[1]), 64'(BASE + 29'd1));
        check("t2_flush_be", 64'(wr_be[1]), 64'h07);
        check("t2_flush_din", wr_din[1] & 64'hFF_FFFF, 64'hC0C0C0);
        check("t2_byte_len", 64'(byte_len), 64'd11);

        // Busy stall of 2000 cycles drops exactly one word
        do_reset();
        motor = 1'b1;
        align();
        run_take(32, 32'h0, 1120, 2000);
        arm = 1'b0;
        cycles(20);
        check("t3_overflow", 64'(overflow), 64'h1);
        check("t3_byte_len", 64'(byte_len), 64'd24);
        check("t3_writes", 64'(wr_addr.size()), 64'd3);
        check("t3_addr2", 64'(wr_addr[2]), 64'(BASE + 29'd2));
        check("t3_stalled", 64'(stall_cnt > 100), 64'h1);
        check("t3_we_stable", 64'(stall_bad), 64'h0);

        // Reset in the middle of a take with a stuck write
        do_reset();
        motor = 1'b1;
        align();
        run_take(16, 32'h0, 1120, 100000);
        check("t6_pre_we", 64'(ddram_we), 64'h1);
        check("t6_pre_overflow", 64'(overflow), 64'h1);
        reset = 1'b1;
        cycles(1);
        check("t6_we", 64'(ddram_we), 64'h0);
        check("t6_recording", 64'(recording), 64'h0);
        check("t6_byte_len", 64'(byte_len), 64'h0);
        check("t6_overflow", 64'(overflow), 64'h0);
        reset = 1'b0;
        ddram_busy = 1'b0;
        arm = 1'b0;

        // Upload of a 16-byte take starting high: sequential data reads then header
        do_reset();
        motor = 1'b1;
        align();
        run_take(16, 32'h5555_5555, 0, 0);
        arm = 1'b0;
        cycles(20);
        ioctl_upload = 1'b1;
        cycles(2);
        rd0 = rd_cnt;
        for (int i = 0; i < 8; i++) begin
            ioctl_read(25'(OFS + i), d, lat);
            check($sformatf("t5_byte%0d", OFS + i), 64'(d), (i % 2 == 0) ? 64'hC0 : 64'h40);
            if (i == 0) check("t5_miss_lat", 64'(lat > 2), 64'h1);
            else check($sformatf("t5_hit_lat%0d", OFS + i), 64'(lat), 64'd2);
        end
        check("t5_rd_count", 64'(rd_cnt - rd0), 64'd1);
        for (int i = 0; i < NHDR; i++) begin
            ioctl_read(25'(hdr_addr[i]), d, lat);
            check($sformatf("t4_byte%0d", hdr_addr[i]), 64'(d), 64'(hdr_exp[i]));
        end
        ioctl_read(25'(OFS), d, lat);
        check("t4_first_pcm", 64'(d), 64'hC0);
        ioctl_upload = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
